rpn_calc: RTL and testbench

RPN_CALC -- requirements
Module: rpn_calc

---
 rtl/rpn_pkg.sv | 20 ++
 rtl/lifo_store.sv | 49 ++++
 rtl/rpn_calc.sv | 143 ++++++++++++++
 tb/tb_rpn_calc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - operator codes and controller states for the RPN calculator
package rpn_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_EVAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_B  = 3'd1,
        POP_A  = 3'd2,
        EXEC   = 3'd3,
        PUSH_R = 3'd4,
        EMIT   = 3'd5
    } state_e;

endpackage

// File: rtl/lifo_store.sv
// rtl/lifo_store.sv - operand stack: register file with occupancy pointer
module lifo_store #(
    parameter int DEPTH_BITS = 2,
    parameter int WORD_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WORD_BITS-1:0]  push_data,
    output logic [WORD_BITS-1:0]  top_data,
    output logic [DEPTH_BITS:0]   depth
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [WORD_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] top_ptr;
    logic                  full;
    logic                  empty;

    // Occupancy never exceeds DEPTH, so the MSB alone marks a full stack;
    // the low bits double as the next free slot.
    assign full    = depth[DEPTH_BITS];
    assign empty   = (depth == '0);
    assign wr_ptr  = depth[DEPTH_BITS-1:0];
    assign top_ptr = wr_ptr - DEPTH_BITS'(1);
    assign top_data = mem[top_ptr];

    // Occupancy pointer; push and pop are never requested together
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + (DEPTH_BITS + 1)'(1);
        end else if (pop && !empty) begin
            depth <= depth - (DEPTH_BITS + 1)'(1);
        end
    end

    // Storage write; contents are left unreset since depth gates every read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rpn_calc.sv
// rtl/rpn_calc.sv - token-driven RPN calculator with stack-based evaluation
module rpn_calc
    import rpn_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int WORD_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_op,
    input  logic [WORD_BITS-1:0]  in_data,
    output logic                  out_valid,
    output logic [WORD_BITS-1:0]  out_data,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic [DEPTH_BITS:0]   depth
);

    state_e               state;
    state_e               state_nx;
    op_e                  in_op;
    op_e                  op_q;
    logic                 accept;
    logic                 full;
    logic                 empty;
    logic                 has_two;
    logic                 push;
    logic                 pop;
    logic [WORD_BITS-1:0] push_data;
    logic [WORD_BITS-1:0] top_data;
    logic [WORD_BITS-1:0] opnd_a;
    logic [WORD_BITS-1:0] opnd_b;
    logic [WORD_BITS-1:0] result;

    function automatic logic [WORD_BITS-1:0] alu(
        input op_e                  op,
        input logic [WORD_BITS-1:0] a,
        input logic [WORD_BITS-1:0] b
    );
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            default: alu = b;
        endcase
    endfunction

    assign in_op   = op_e'(in_data[1:0]);
    assign accept  = in_valid && in_ready;
    assign full    = depth[DEPTH_BITS];
    assign empty   = (depth == '0);
    assign has_two = (depth[DEPTH_BITS:1] != '0);

    lifo_store #(
        .DEPTH_BITS (DEPTH_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top_data  (top_data),
        .depth     (depth)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: only operators with enough operands leave IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && in_is_op) begin
                    if (in_op == OP_EVAL) begin
                        if (!empty) state_nx = EMIT;
                    end else if (has_two) begin
                        state_nx = POP_B;
                    end
                end
            end
            POP_B:   state_nx = POP_A;
            POP_A:   state_nx = EXEC;
            EXEC:    state_nx = PUSH_R;
            PUSH_R:  state_nx = IDLE;
            EMIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stack controls: operand pushes from IDLE, result push from PUSH_R
    always_comb begin
        in_ready  = (state == IDLE);
        push      = 1'b0;
        pop       = 1'b0;
        push_data = in_data;
        case (state)
            IDLE:          push = accept && !in_is_op && !full;
            POP_B, POP_A:  pop  = 1'b1;
            PUSH_R: begin
                push      = 1'b1;
                push_data = result;
            end
            EMIT:          pop  = 1'b1;
            default: ;
        endcase
    end

    // Result and error pulses; errors only arise from IDLE accepts, so they
    // can never coincide with the out_valid that follows EMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            out_valid     <= (state == EMIT);
            if (state == EMIT) out_data <= top_data;
            err_overflow  <= accept && !in_is_op && full;
            err_underflow <= accept && in_is_op &&
                             ((in_op == OP_EVAL) ? empty : !has_two);
        end
    end

    // Operand capture and execution; b is the top, a the deeper operand
    always_ff @(posedge clk) begin
        if (accept && in_is_op) op_q <= in_op;
        if (state == POP_B)     opnd_b <= top_data;
        if (state == POP_A)     opnd_a <= top_data;
        if (state == EXEC)      result <= alu(op_q, opnd_a, opnd_b);
    end

endmodule

// File: tb/tb_rpn_calc.sv
// tb/tb_rpn_calc.sv - directed self-checking bench for rpn_calc
module tb_rpn_calc;

    localparam logic [7:0] C_ADD  = 8'd0;
    localparam logic [7:0] C_SUB  = 8'd1;
    localparam logic [7:0] C_MUL  = 8'd2;
    localparam logic [7:0] C_EVAL = 8'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_is_op = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       err_overflow;
    logic       err_underflow;
    logic [2:0] depth;

    int tests = 0;
    int fails = 0;

    rpn_calc #(.DEPTH_BITS(2), .WORD_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_op      (in_is_op),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .depth         (depth)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_is_op = 1'b0; in_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer a token, hold it until accepted; returns at the negedge after acceptance
    task automatic send(input logic is_op, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_is_op = is_op; in_data = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%0d required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_is_op = 1'b0; in_data = 8'hA5;
    endtask

    // Wait (bounded) for out_valid; returns at the negedge where it was seen
    task automatic wait_out(output logic got, output logic [7:0] d, output logic errs);
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d = out_data;
        errs = err_overflow | err_underflow;
    endtask

    task automatic eval_expect(input string name, input logic [7:0] exp);
        logic got, errs;
        logic [7:0] d;
        send(1'b1, C_EVAL);
        wait_out(got, d, errs);
        tests++;
        if (got !== 1'b1) begin
            fails++; $display("FAIL %s_valid: out_valid=%0d required 1", name, got);
        end
        tests++;
        if (d !== exp) begin
            fails++; $display("FAIL %s_data: out_data=%0d required %0d", name, d, exp);
        end
        tests++;
        if (errs !== 1'b0) begin
            fails++; $display("FAIL %s_excl: err=%0d required 0 with out_valid", name, errs);
        end
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if (depth !== 3'd0) begin fails++; $display("FAIL rst_depth: got %0d required 0", depth); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0d required 1", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0d required 0", out_valid); end
        tests++;
        if (out_data !== 8'd0) begin fails++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
        tests++;
        if ({err_overflow, err_underflow} !== 2'b00) begin
            fails++; $display("FAIL rst_errs: got %b required 00", {err_overflow, err_underflow});
        end
    endtask

    task automatic test_add;
        int busy;
        send(1'b0, 8'd3);
        send(1'b0, 8'd4);
        tests++;
        if (depth !== 3'd2) begin fails++; $display("FAIL add_depth2: got %0d required 2", depth); end
        send(1'b1, C_ADD);
        busy = 0;
        while (!in_ready && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        tests++;
        if (busy !== 4) begin fails++; $display("FAIL add_busy: got %0d cycles required 4", busy); end
        tests++;
        if (depth !== 3'd1) begin fails++; $display("FAIL add_depth1: got %0d required 1", depth); end
        eval_expect("add", 8'd7);
        tests++;
        if (depth !== 3'd0) begin fails++; $display("FAIL add_depth0: got %0d required 0", depth); end
    endtask

    task automatic test_wrap;
        send(1'b0, 8'd200); send(1'b0, 8'd100); send(1'b1, C_ADD);
        eval_expect("add_wrap", 8'd44);
        send(1'b0, 8'd20); send(1'b0, 8'd20); send(1'b1, C_MUL);
        eval_expect("mul_wrap", 8'd144);
    endtask

    task automatic test_sub;
        send(1'b0, 8'd10); send(1'b0, 8'd3); send(1'b1, C_SUB);
        eval_expect("sub", 8'd7);
        send(1'b0, 8'd3); send(1'b0, 8'd10); send(1'b1, C_SUB);
        eval_expect("sub_neg", 8'd249);
    endtask

    task automatic test_overflow;
        send(1'b0, 8'd11); send(1'b0, 8'd22); send(1'b0, 8'd33); send(1'b0, 8'd44);
        tests++;
        if (depth !== 3'd4) begin fails++; $display("FAIL ovf_full: depth %0d required 4", depth); end
        send(1'b0, 8'd55);
        tests++;
        if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %0d required 1", err_overflow); end
        tests++;
        if (depth !== 3'd4) begin fails++; $display("FAIL ovf_depth: got %0d required 4", depth); end
        @(negedge clk);
        tests++;
        if (err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle: got %0d required 0", err_overflow); end
        eval_expect("ovf_eval", 8'd44);
        tests++;
        if (depth !== 3'd3) begin fails++; $display("FAIL ovf_depth3: got %0d required 3", depth); end
        do_reset();
    endtask

    task automatic test_underflow;
        int drops;
        logic got, errs;
        logic [7:0] d;
        send(1'b0, 8'd7);
        send(1'b1, C_ADD);
        tests++;
        if (err_underflow !== 1'b1) begin fails++; $display("FAIL unf_add_pulse: got %0d required 1", err_underflow); end
        tests++;
        if (depth !== 3'd1) begin fails++; $display("FAIL unf_add_depth: got %0d required 1", depth); end
        drops = 0;
        for (int i = 0; i < 4; i++) begin
            if (!in_ready) drops++;
            @(negedge clk);
        end
        tests++;
        if (drops !== 0) begin fails++; $display("FAIL unf_ready: %0d busy cycles required 0", drops); end
        eval_expect("unf_keep", 8'd7);
        send(1'b1, C_EVAL);
        tests++;
        if (err_underflow !== 1'b1) begin fails++; $display("FAIL unf_eval_pulse: got %0d required 1", err_underflow); end
        wait_out(got, d, errs);
        tests++;
        if (got !== 1'b0) begin fails++; $display("FAIL unf_eval_valid: out_valid=%0d required 0", got); end
    endtask

    task automatic test_ignore;
        int bad;
        send(1'b0, 8'd9);
        in_valid = 1'b0; in_is_op = 1'b1; in_data = C_ADD;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (depth !== 3'd1 || err_underflow || err_overflow || out_valid) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL ignore_idle: %0d disturbed cycles required 0", bad); end
        eval_expect("ignore", 8'd9);
    endtask

    task automatic test_abort;
        int bad;
        do_reset();
        send(1'b0, 8'd2); send(1'b0, 8'd3); send(1'b1, C_MUL);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (depth !== 3'd0) begin fails++; $display("FAIL abort_depth: got %0d required 0", depth); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %0d required 1", in_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid || depth !== 3'd0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL abort_quiet: %0d bad cycles required 0", bad); end
        send(1'b0, 8'd5);
        eval_expect("abort_after", 8'd5);
    endtask

    task automatic test_back_to_back;
        send(1'b0, 8'd6); send(1'b0, 8'd5); send(1'b0, 8'd3);
        send(1'b1, C_SUB);
        send(1'b1, C_MUL);
        eval_expect("chain", 8'd12);
        tests++;
        if (depth !== 3'd0) begin fails++; $display("FAIL chain_depth: got %0d required 0", depth); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_overflow();
        test_underflow();
        test_ignore();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
